ahb_lite_slave_sram: RTL
========================

AHB_LITE_SLAVE_SRAM -- requirements
Module: ahb_lite_slave_sram

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, log2 of memory depth in 32-bit words (64 words).
REQ-002 SHALL have parameter WAIT_STATES, default 0, HREADYOUT-low cycles inserted per OKAY data phase (0..15).
REQ-003 SHALL have port HCLK  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port HSEL  input  1  slave select.
REQ-006 SHALL have port HADDR  input  32  byte address, address phase.
REQ-007 SHALL have port HWRITE  input  1  1=write, 0=read, address phase.
REQ-008 SHALL have port HSIZE  input  3  transfer size (0=byte, 1=halfword, 2=word).
REQ-009 SHALL have port HTRANS  input  2  transfer type; only bit 1 is decoded (NONSEQ/SEQ vs IDLE/BUSY).
REQ-010 SHALL have port HWDATA  input  32  write data, data phase.
REQ-011 SHALL have port HREADY  input  1  bus-wide ready (previous transfer complete).
REQ-012 SHALL have port HRDATA  output  32  read data.
REQ-013 SHALL have port HREADYOUT  output  1  slave ready.
REQ-014 SHALL have port HRESP  output  1  0=OKAY, 1=ERROR.

Function
REQ-015 SHALL accept an address phase when HSEL & HREADY & HTRANS[1] are all 1 at a rising edge, latching HADDR, HWRITE and HSIZE.
REQ-016 SHALL treat an accepted transfer as erroneous if any of the following holds: HSIZE>2; HSIZE=1 with HADDR[0]=1; HSIZE=2 with HADDR[1:0]!=0; HADDR[31:DEPTH_LOG2+2] nonzero.
REQ-017 SHALL implement FSM states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-018 SHALL transition on an accepted transfer as follows: erroneous -> ERR1; else WAIT_STATES>0 -> WAIT; else -> DATA.
REQ-019 SHALL, in IDLE, drive HREADYOUT=1 and HRESP=0.
REQ-020 SHALL hold WAIT for exactly WAIT_STATES cycles with HREADYOUT=0 and HRESP=0, using a 4-bit down-counter loaded at acceptance, then go to DATA.
REQ-021 SHALL, in DATA, drive HREADYOUT=1 and HRESP=0; the transfer completes in this cycle.
REQ-022 SHALL drive ERR1 with HREADYOUT=0 and HRESP=1 for one cycle, then go to ERR2.
REQ-023 SHALL drive ERR2 with HREADYOUT=1 and HRESP=1 for one cycle; an erroneous transfer never modifies memory.
REQ-024 SHALL, from DATA or ERR2, go to the next state per REQ-018 if a new transfer is accepted in the same cycle, else to IDLE; back-to-back transfers need no idle cycle.
REQ-025 SHALL complete a selected IDLE/BUSY transfer with zero-wait OKAY and perform no memory access.
REQ-026 SHALL, for writes, sample HWDATA in the DATA cycle and update memory at that cycle's closing edge.
REQ-027 SHALL, for writes, enable byte lanes little-endian: byte -> lane HADDR[1:0]; halfword -> lanes {HADDR[1],0} and {HADDR[1],1}; word -> all four lanes.
REQ-028 SHALL, for reads, drive HRDATA with the full 32-bit word at the latched word address during DATA, and 32'h0 in all other states.
REQ-029 SHALL return newly written data on a read immediately following a write to the same word, with no stall beyond WAIT_STATES.
REQ-030 SHALL ignore HWDATA outside DATA cycles of write transfers.
REQ-031 SHALL accept no new address phase while HREADY=0 (e.g. in WAIT or ERR1).

Reset
REQ-032 SHALL, on HRESETn low, immediately enter IDLE with HREADYOUT=1, HRESP=0, HRDATA=0, wait counter 0 and latched address/control cleared.
REQ-033 SHALL, on a reset asserted mid-transfer, abort the transfer; a write not yet in its DATA closing edge is discarded.
REQ-034 SHALL not reset memory contents; they are undefined until written.

Verification
REQ-035 SHALL verify: WAIT_STATES=0, word write 0xDEADBEEF to 0x10 then read 0x10 back-to-back -> HREADYOUT stays 1, read returns 0xDEADBEEF.
REQ-036 SHALL verify: word write 0x11223344 to 0x20, byte write 0xAA to 0x22 -> read 0x20 returns 0x11AA3344.
REQ-037 SHALL verify: WAIT_STATES=3, read -> exactly 3 HREADYOUT=0 cycles, then data with HREADYOUT=1.
REQ-038 SHALL verify: word access to 0x102 (misaligned) and to 0x100 (out of range, DEPTH_LOG2=6) -> each gives HREADYOUT 0 then 1 with HRESP=1 for both cycles, memory unchanged.
REQ-039 SHALL verify: selected HTRANS=IDLE -> HREADYOUT=1, HRESP=0, no write occurs.
REQ-040 SHALL verify: HRESETn pulsed low during WAIT of a write -> outputs return to IDLE values at once, target word unchanged.

Source files
------------

// File: rtl/ahb_lite_slave_sram.sv
// AHB-Lite SRAM slave with optional wait states and two-cycle ERROR
// response for misaligned, oversized or out-of-range accesses.
module ahb_lite_slave_sram #(
    parameter int DEPTH_LOG2  = 6,
    parameter int WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP
);

    typedef enum logic [2:0] {IDLE, WAIT, DATA, ERR1, ERR2} state_t;

    state_t state, state_nxt, start_state;
    logic [3:0] cnt, cnt_nxt;
    logic [DEPTH_LOG2-1:0] waddr;
    logic [1:0] boff;
    logic [1:0] size;
    logic wr;
    logic accept;
    logic bad;
    logic [3:0] lanes;
    logic unused_ok;

    logic [31:0] mem [2**DEPTH_LOG2];

    assign unused_ok = HTRANS[0];

    // A new address phase is only taken where the previous one is finishing.
    assign accept = HSEL & HREADY & HTRANS[1] &
                    (state inside {IDLE, DATA, ERR2});

    assign bad = (HSIZE > 3'd2) |
                 ((HSIZE == 3'd1) & HADDR[0]) |
                 ((HSIZE == 3'd2) & (|HADDR[1:0])) |
                 (|HADDR[31:DEPTH_LOG2+2]);

    always_comb begin
        start_state = DATA;
        if (bad)
            start_state = ERR1;
        else if (WAIT_STATES > 0)
            start_state = WAIT;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE, DATA, ERR2: begin
                if (accept) begin
                    state_nxt = start_state;
                    cnt_nxt   = 4'(WAIT_STATES);
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1)
                    state_nxt = DATA;
            end
            ERR1:    state_nxt = ERR2;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
            cnt   <= '0;
            waddr <= '0;
            boff  <= '0;
            size  <= '0;
            wr    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                waddr <= HADDR[DEPTH_LOG2+1:2];
                boff  <= HADDR[1:0];
                size  <= HSIZE[1:0];
                wr    <= HWRITE;
            end
        end
    end

    always_comb begin
        lanes = 4'hF;
        unique case (size)
            2'd0:    lanes = 4'b0001 << boff;
            2'd1:    lanes = boff[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'hF;
        endcase
    end

    // Storage has no reset; contents are undefined until written.
    always_ff @(posedge HCLK) begin
        if (HRESETn && (state == DATA) && wr) begin
            for (int i = 0; i < 4; i++)
                if (lanes[i])
                    mem[waddr][8*i +: 8] <= HWDATA[8*i +: 8];
        end
    end

    assign HRDATA    = ((state == DATA) && !wr) ? mem[waddr] : 32'h0;
    assign HREADYOUT = !((state == WAIT) || (state == ERR1));
    assign HRESP     = (state == ERR1) || (state == ERR2);

endmodule
